// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one combinational ALU
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_sel0,
  input  logic [2:0]       req_sel1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] SEL_ILLEGAL = 3'd3;

  state_t state;
  state_t state_next;
  logic   owner;
  logic   last_grant;
  logic   grant_port;
  logic   accept;

  // A lone requester always wins; a tie goes to the port opposite the last winner.
  assign grant_port = (req_valid == 2'b10) || ((req_valid == 2'b11) && !last_grant);

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          req_ready  = grant_port ? 2'b10 : 2'b01;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        if (rsp_ready[owner]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (accept) begin
        owner      <= grant_port;
        last_grant <= grant_port;
      end
    end
  end

  // Operand registers only move on an accept, so the ALU pins stay quiet in IDLE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel <= 3'd0;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (accept) begin
      alu_sel <= grant_port ? req_sel1 : req_sel0;
      alu_a   <= grant_port ? req_a1 : req_a0;
      alu_b   <= grant_port ? req_b1 : req_b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == EXEC) begin
      if (alu_sel == SEL_ILLEGAL) begin
        rsp_out  <= '0;
        rsp_zero <= 1'b1;
        rsp_err  <= 1'b1;
      end else begin
        rsp_out  <= alu_out;
        rsp_zero <= alu_zero;
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter with table vectors, corner sequences and random traffic
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [2:0]   req_sel0 = 3'd0;
  logic [2:0]   req_sel1 = 3'd0;
  logic [W-1:0] req_a0 = '0;
  logic [W-1:0] req_b0 = '0;
  logic [W-1:0] req_a1 = '0;
  logic [W-1:0] req_b1 = '0;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready = 2'b11;
  logic [W-1:0] rsp_out;
  logic         rsp_zero;
  logic         rsp_err;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  int   tests = 0;
  int   failed = 0;
  logic last_g = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // External ALU; op 3 returns junk so the arbiter must ignore it.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_out = alu_a & alu_b;
      3'd1:    alu_out = alu_a | alu_b;
      3'd2:    alu_out = alu_a + alu_b;
      3'd4:    alu_out = alu_a ^ alu_b;
      3'd5:    alu_out = ~(alu_a | alu_b);
      3'd6:    alu_out = alu_a - alu_b;
      3'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected response {err, zero, out} computed from integer arithmetic.
  function automatic logic [W+1:0] ref_rsp(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (sel)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = W'(sa + sb);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a | b);
      3'd6:    r = W'(sa - sb);
      3'd7:    r = (sa < sb) ? W'(1) : W'(0);
      default: return {1'b1, 1'b1, {W{1'b0}}};
    endcase
    return {1'b0, (r == '0), r};
  endfunction

  // Runs one transaction from IDLE (called just after a negedge); ends in IDLE after a negedge.
  task automatic txn(input logic [1:0] v, input logic [2:0] s0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [2:0] s1, input logic [W-1:0] a1, input logic [W-1:0] b1, input int bp,
                     input logic ep, input logic [W-1:0] eo, input logic ez, input logic ee);
    logic [1:0] oh;
    oh = ep ? 2'b10 : 2'b01;
    req_valid = v;
    req_sel0 = s0; req_a0 = a0; req_b0 = b0;
    req_sel1 = s1; req_a1 = a1; req_b1 = b1;
    rsp_ready = (bp > 0) ? 2'b00 : 2'b11;
    #1 check("req_ready_grant", W'(req_ready), W'(oh));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("exec_rsp_valid", W'(rsp_valid), W'(0));
    check("exec_alu_sel", W'(alu_sel), W'(ep ? s1 : s0));
    check("exec_alu_a", alu_a, ep ? a1 : a0);
    check("exec_alu_b", alu_b, ep ? b1 : b0);
    @(negedge clk);
    check("rsp_valid", W'(rsp_valid), W'(oh));
    check("rsp_out", rsp_out, eo);
    check("rsp_zero", W'(rsp_zero), W'(ez));
    check("rsp_err", W'(rsp_err), W'(ee));
    check("resp_req_ready", W'(req_ready), W'(0));
    for (int i = 0; i < bp; i++) begin
      rsp_ready = ~oh;
      @(negedge clk);
      check("bp_rsp_valid", W'(rsp_valid), W'(oh));
      check("bp_rsp_out", rsp_out, eo);
      check("bp_alu_a", alu_a, ep ? a1 : a0);
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    #1 check("retire_rsp_valid", W'(rsp_valid), W'(0));
    last_g = ep;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [1:0]   v;
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           bp;
    logic         port;
    logic [W-1:0] out;
    logic         zero;
    logic         err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   v;
    logic [2:0]   s0, s1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ep;
    logic [W+1:0] er;
    logic [1:0]   er_ready;

    vecs[0] = '{2'b01, 3'd2, 32'd5, 32'd7, 0, 1'b0, 32'd12, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 3'd1, 32'hF0, 32'h0F, 5, 1'b1, 32'hFF, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 3'd3, 32'd9, 32'd9, 0, 1'b0, 32'd0, 1'b1, 1'b1};
    vecs[3] = '{2'b01, 3'd0, 32'hC, 32'hA, 0, 1'b0, 32'd8, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 3'd6, 32'd5, 32'd7, 2, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 3'd7, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, 32'd1, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 3'd6, 32'd3, 32'd3, 3, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[7] = '{2'b10, 3'd7, 32'd0, 32'hFFFF_FFFF, 0, 1'b1, 32'd0, 1'b1, 1'b0};
    vecs[8] = '{2'b01, 3'd5, 32'd0, 32'd0, 1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_rsp_out", rsp_out, W'(0));
    check("rst_rsp_zero", W'(rsp_zero), W'(0));
    check("rst_rsp_err", W'(rsp_err), W'(0));
    check("rst_alu_sel", W'(alu_sel), W'(0));
    check("rst_alu_a", alu_a, W'(0));
    check("rst_alu_b", alu_b, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Table vectors (ports given identical operands on ties)
    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].v, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].a, vecs[i].b,
          vecs[i].bp, vecs[i].port, vecs[i].out, vecs[i].zero, vecs[i].err);
    end

    // Continuous tie: grants alternate every 3 cycles starting with port 0
    do_reset();
    req_valid = 2'b11;
    req_sel0 = 3'd6; req_a0 = 32'd3; req_b0 = 32'd3;
    req_sel1 = 3'd7; req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 18; k++) begin
      #1;
      er_ready = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01);
      check("rr_req_ready", W'(req_ready), W'(er_ready));
      if (k % 3 == 2) begin
        check("rr_rsp_valid", W'(rsp_valid), ((k / 3) % 2 == 1) ? W'(2) : W'(1));
        check("rr_rsp_out", rsp_out, ((k / 3) % 2 == 1) ? W'(1) : W'(0));
        check("rr_rsp_zero", W'(rsp_zero), ((k / 3) % 2 == 1) ? W'(0) : W'(1));
      end else begin
        check("rr_rsp_idle", W'(rsp_valid), W'(0));
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
    #1;

    // Back-pressure on port 1 with port 0 waiting
    do_reset();
    req_valid = 2'b10;
    req_sel1 = 3'd1; req_a1 = 32'hF0; req_b1 = 32'h0F;
    rsp_ready = 2'b00;
    #1 check("bp_grant1", W'(req_ready), W'(2));
    @(posedge clk);
    #1 req_valid = 2'b01;
    req_sel0 = 3'd2; req_a0 = 32'd1; req_b0 = 32'd2;
    @(negedge clk);
    check("bp_exec_ready", W'(req_ready), W'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", W'(rsp_valid), W'(2));
      check("bp_hold_out", rsp_out, 32'hFF);
      check("bp_hold_ready", W'(req_ready), W'(0));
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    #1 check("bp_grant0", W'(req_ready), W'(1));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("bp_p0_valid", W'(rsp_valid), W'(1));
    check("bp_p0_out", rsp_out, 32'd3);
    @(negedge clk);
    #1;

    // Reset during EXEC
    req_valid = 2'b01;
    req_sel0 = 3'd2; req_a0 = 32'd4; req_b0 = 32'd4;
    rsp_ready = 2'b11;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_exec_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_exec_alu_a", alu_a, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    last_g = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec_no_stale", W'(rsp_valid), W'(0));
    end
    #1 txn(2'b11, 3'd2, 32'd1, 32'd1, 3'd2, 32'd9, 32'd9, 0, 1'b0, 32'd2, 1'b0, 1'b0);

    // Reset during RESP
    req_valid = 2'b10;
    req_sel1 = 3'd2; req_a1 = 32'd6; req_b1 = 32'd1;
    rsp_ready = 2'b00;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_pre_valid", W'(rsp_valid), W'(2));
    rst_n = 1'b0;
    #1 check("rst_resp_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_resp_rsp_out", rsp_out, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    last_g = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_resp_no_stale", W'(rsp_valid), W'(0));
    end
    #1 txn(2'b11, 3'd6, 32'd10, 32'd4, 3'd6, 32'd1, 32'd1, 0, 1'b0, 32'd6, 1'b0, 1'b0);

    // Random traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      v  = 2'($urandom_range(1, 3));
      s0 = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      a0 = $urandom;
      a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      ep = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ~last_g;
      er = ep ? ref_rsp(s1, a1, b1) : ref_rsp(s0, a0, b0);
      txn(v, s0, a0, b0, s1, a1, b1, int'($urandom_range(0, 3)), ep, er[W-1:0], er[W], er[W+1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational ALU between two requesters, e.g. the EX stage (port 0) and a multi-cycle helper unit (port 1), using valid/ready handshakes. It arbitrates round-robin, latches the winner's operands, and drives the ALU from registers for one cycle. It then captures the result and returns it to the winning port with a valid/ready response. It sits between the requesters and the ALU's `sel`/`a`/`b`/`out`/`out_zero` pins.

## Interface
- `WIDTH`, default 32: operand/result width, two's complement.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port request accepted this cycle.
- `req_sel0`, `req_sel1` in 3 each: ALU op code per port.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in WIDTH each: operands.
- `rsp_valid[1:0]` out 2: per-port response valid.
- `rsp_ready[1:0]` in 2: per-port response consumed.
- `rsp_out` out WIDTH: result (shared bus; meaningful only for the port with `rsp_valid` set).
- `rsp_zero` out 1: result equals zero.
- `rsp_err` out 1: request used an unsupported op code (3).
- `alu_sel` out 3, `alu_a` out WIDTH, `alu_b` out WIDTH: drive the ALU.
- `alu_out` in WIDTH, `alu_zero` in 1: from the ALU.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is set, grant one port.
  - If only one port is valid, that port wins.
  - If both are valid, the port opposite `last_grant` wins.
  - The winner gets `req_ready` high combinationally. The other port's `req_ready` stays low.
  - On the edge: latch the winner's sel, a and b; record the port in `owner`; set `last_grant = owner`; go to EXEC.
- **EXEC**
  - `alu_sel`, `alu_a` and `alu_b` are driven from the latched registers.
  - On the edge: capture `alu_out` and `alu_zero`; go to RESP.
  - If the latched sel is 3: capture `rsp_out = 0`, `rsp_zero = 1`, `rsp_err = 1`, ignoring the ALU.
  - For any other sel: `rsp_err = 0`.
- **RESP**
  - `rsp_valid[owner] = 1`; the other bit is 0.
  - `rsp_out`, `rsp_zero` and `rsp_err` are held stable.
  - When `rsp_ready[owner]` is 1, go to IDLE on the edge.
  - `rsp_ready` of the non-owner port is ignored.
- `req_ready` is 0 in EXEC and RESP. There is no accept in the same cycle a response retires.
- In IDLE and RESP, the ALU inputs keep their last latched values (no toggling).
- Request fields of a non-granted port are don't-care and are never sampled.
- Requesters must hold `req_*` stable while `req_valid` is high and `req_ready` is low.
- **Reset values:**
  - State: IDLE.
  - `last_grant`: 1, so port 0 wins the first tie.
  - `req_ready`: 0 (no requests pending).
  - `rsp_valid`: 0.
  - `rsp_out`: 0.
  - `rsp_zero`: 0.
  - `rsp_err`: 0.
  - `alu_sel`: 0.
  - `alu_a`: 0.
  - `alu_b`: 0.
  - `owner`: 0.
- Reset asserted mid-transaction aborts it immediately. No response is issued; the requester must reissue.

## Timing
- Request accepted at edge T (valid and ready both high).
- ALU is driven in cycle T..T+1 (the EXEC cycle).
- Result is captured at edge T+1.
- `rsp_valid` is high from cycle T+1 onward, until the handshake edge.
- Minimum issue interval is 3 cycles per operation, when `rsp_ready` is held high.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.
- Arbitration is fair: with both ports continuously requesting, grants alternate 0,1,0,1.
- A port requesting alone is granted every transaction regardless of `last_grant`.
- Back-pressure: `rsp_ready` low holds RESP indefinitely, with outputs stable and both `req_ready` bits low.

## Test plan
- **Reset:** `rst_n` low, then high.
  - Required: all outputs 0, IDLE.
  - Then port 0 requests sel=2, a=5, b=7 → `req_ready[0]` at T; `rsp_valid[0]` at T+1 with `rsp_out`=12, `rsp_zero`=0, `rsp_err`=0.
- **Tie and round-robin:** both ports request continuously.
  - Port 0: sel=6, a=3, b=3.
  - Port 1: sel=7, a=-1, b=0.
  - Required: grants alternate 0,1,0,1.
  - Port 0 gets `rsp_out`=0 with `rsp_zero`=1.
  - Port 1 gets `rsp_out`=1 with `rsp_zero`=0.
  - One grant every 3 cycles.
- **Back-pressure:** port 1 requests sel=1, a=0xF0, b=0x0F with `rsp_ready[1]` low for 5 cycles.
  - Required: `rsp_valid[1]` and `rsp_out`=0xFF held 5 cycles.
  - A port 0 request stays unaccepted throughout.
  - Port 0 is granted in the IDLE cycle after `rsp_ready[1]` rises.
- **Illegal op:** port 0 requests sel=3, a=9, b=9.
  - Required: `rsp_out`=0, `rsp_zero`=1, `rsp_err`=1.
  - A following sel=0, a=0xC, b=0xA request returns 8 with `rsp_err`=0.
- **Reset mid-operation:** assert `rst_n` low during EXEC, then during RESP.
  - Required: `rsp_valid` drops asynchronously to 0; state returns to IDLE.
  - No stale response after release; the next tie is won by port 0.
- **Non-owner ready:** port 0 transaction in RESP with `rsp_ready[1]`=1 and `rsp_ready[0]`=0.
  - Required: remains in RESP and `rsp_valid[0]` stays high.
